// File: rtl/twiddle_sequencer.sv
// Twiddle ROM sweep sequencer: on start, walks the ROM address 0..N-1 once and
// presents each registered twiddle with its bin index, then pulses done.
module twiddle_sequencer #(
  parameter int addr_width = 4,
  parameter int data_width = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  clear_overrun,
  output logic [addr_width-1:0] rom_addr,
  input  logic [data_width-1:0] rom_real,
  input  logic [data_width-1:0] rom_imaj,
  output logic                  busy,
  output logic                  tw_valid,
  output logic [addr_width-1:0] tw_index,
  output logic [data_width-1:0] tw_real,
  output logic [data_width-1:0] tw_imaj,
  output logic                  tw_last,
  output logic                  done,
  output logic                  overrun,
  output logic [7:0]            frame_count,
  output logic [1:0]            state_dbg
);

  // Handshake: start is a level request sampled on the rising edge. It is
  // accepted only while busy is low; a start seen while busy is high is
  // dropped and latches overrun until clear_overrun (a same-cycle set wins).

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [addr_width-1:0] last_addr = '1;
  localparam logic [addr_width-1:0] addr_one  = 1;

  state_t                state;
  state_t                state_next;
  logic [addr_width-1:0] addr_next;
  logic                  drain_cnt;
  logic                  drain_next;
  logic                  issue;

  logic                  v1;
  logic [addr_width-1:0] idx1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rom_addr  <= '0;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_next;
      rom_addr  <= addr_next;
      drain_cnt <= drain_next;
    end
  end

  always_comb begin
    state_next = state;
    addr_next  = rom_addr;
    drain_next = drain_cnt;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = ISSUE;
          addr_next  = '0;
        end
      end
      ISSUE: begin
        issue = 1'b1;
        if (rom_addr == last_addr) begin
          state_next = DRAIN;
          drain_next = 1'b0;
        end else begin
          addr_next = rom_addr + addr_one;
        end
      end
      DRAIN: begin
        // Two cycles cover the ROM read and the output register.
        if (drain_cnt) begin
          state_next = IDLE;
        end else begin
          drain_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Stage 1 tracks the address whose data the ROM returns next cycle; stage 2
  // lines up with the registered twiddle words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1       <= 1'b0;
      idx1     <= '0;
      tw_valid <= 1'b0;
      tw_index <= '0;
      tw_real  <= '0;
      tw_imaj  <= '0;
      tw_last  <= 1'b0;
      done     <= 1'b0;
    end else begin
      v1       <= issue;
      if (issue) begin
        idx1 <= rom_addr;
      end
      tw_valid <= v1;
      if (v1) begin
        tw_index <= idx1;
        tw_real  <= rom_real;
        tw_imaj  <= rom_imaj;
      end
      tw_last  <= v1 && (idx1 == last_addr);
      done     <= v1 && (idx1 == last_addr);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun     <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      if (start && busy) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
      if (done) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule
